// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pkg
// Brief    : Shared widths, accumulator state encoding and saturating add.
// Revision : 1.0
// ============================================================================
package dsp_pkg;

    localparam int unsigned DSP_DATA_WIDTH = 33;
    localparam int unsigned DSP_ACC_WIDTH  = 48;
    localparam int unsigned DSP_CNT_WIDTH  = 16;
    localparam int unsigned SAT_W          = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    // Result is {overflow, sum}; the sum clamps to 2^width-1 (width <= SAT_W).
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      width
    );
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] limit;
        logic             over;
        sum   = {1'b0, a} + {1'b0, b};
        limit = ~({SAT_W{1'b1}} << width);
        over  = sum[SAT_W] | (sum[SAT_W-1:0] > limit);
        if (over) begin
            sat_add = {1'b1, limit};
        end else begin
            sat_add = {1'b0, sum[SAT_W-1:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Brief    : One-entry valid/ready output slice holding sum, count and ovf.
// Revision : 1.0
// ============================================================================
module axis_out_reg #(
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] in_data,
    input  logic [CNT_WIDTH-1:0] in_count,
    input  logic                 in_ovf,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf,
    input  logic                 out_ready
);

    // Free to load when empty or when the held entry leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_count <= in_count;
            out_ovf   <= in_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_packet_accum.sv
`default_nettype none
// ============================================================================
// Module   : dsp_packet_accum
// Brief    : Sums unsigned samples per AXI-Stream packet with saturation.
// Revision : 1.0
// ============================================================================
module dsp_packet_accum
    import dsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DSP_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH  = DSP_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [ACC_WIDTH-1:0]  m_axis_data,
    output logic [CNT_WIDTH-1:0]  m_axis_count,
    output logic                  m_axis_ovf,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready
);

    acc_state_t           state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next, base_acc, beat_acc;
    logic [CNT_WIDTH-1:0] cnt, cnt_next, base_cnt, beat_cnt;
    logic                 ovf, ovf_next, base_ovf, beat_ovf;
    logic [SAT_W:0]       acc_res, cnt_res;
    logic                 in_xfer, out_load;

    assign in_xfer     = s_axis_valid && s_axis_ready;
    assign m_axis_last = m_axis_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        // In IDLE the beat starts a fresh packet, so it adds onto zero.
        base_acc = (state == ACC) ? acc : '0;
        base_cnt = (state == ACC) ? cnt : '0;
        base_ovf = (state == ACC) ? ovf : 1'b0;

        acc_res  = sat_add(SAT_W'(base_acc), SAT_W'(s_axis_data), ACC_WIDTH);
        cnt_res  = sat_add(SAT_W'(base_cnt), SAT_W'(1), CNT_WIDTH);
        beat_acc = acc_res[ACC_WIDTH-1:0];
        beat_cnt = cnt_res[CNT_WIDTH-1:0];
        // Bits above the target width are zero by construction; folding them
        // in keeps the whole function result live.
        beat_ovf = base_ovf
                 | acc_res[SAT_W] | (|acc_res[SAT_W-1:ACC_WIDTH])
                 | cnt_res[SAT_W] | (|cnt_res[SAT_W-1:CNT_WIDTH]);

        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        out_load   = 1'b0;

        if (in_xfer) begin
            if (s_axis_last) begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
                ovf_next   = 1'b0;
                out_load   = 1'b1;
            end else begin
                state_next = ACC;
                acc_next   = beat_acc;
                cnt_next   = beat_cnt;
                ovf_next   = beat_ovf;
            end
        end
    end

    axis_out_reg #(
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (out_load),
        .in_data   (beat_acc),
        .in_count  (beat_cnt),
        .in_ovf    (beat_ovf),
        .in_ready  (s_axis_ready),
        .out_valid (m_axis_valid),
        .out_data  (m_axis_data),
        .out_count (m_axis_count),
        .out_ovf   (m_axis_ovf),
        .out_ready (m_axis_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_dsp_packet_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_packet_accum
// Brief    : Directed self-checking bench for dsp_packet_accum (17/20/4 widths).
// Revision : 1.0
// ============================================================================
module tb_dsp_packet_accum;

    localparam int unsigned DW = 17;
    localparam int unsigned AW = 20;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_valid;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_last;
    logic          s_axis_ready;
    logic          m_axis_valid;
    logic [AW-1:0] m_axis_data;
    logic [CW-1:0] m_axis_count;
    logic          m_axis_ovf;
    logic          m_axis_last;
    logic          m_axis_ready;

    int checks   = 0;
    int failures = 0;

    dsp_packet_accum #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_count (m_axis_count),
        .m_axis_ovf   (m_axis_ovf),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic result(input string tag, input logic [31:0] d, input logic [31:0] c,
                          input logic o);
        chk({tag, "_valid"}, 32'(m_axis_valid), 32'd1);
        chk({tag, "_last"},  32'(m_axis_last),  32'd1);
        chk({tag, "_data"},  32'(m_axis_data),  d);
        chk({tag, "_count"}, 32'(m_axis_count), c);
        chk({tag, "_ovf"},   32'(m_axis_ovf),   32'(o));
    endtask

    // Present one beat from a falling edge; return at the next falling edge.
    task automatic drive(input logic [DW-1:0] d, input logic l);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        @(negedge clk);
    endtask

    task automatic idle();
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        s_axis_valid = 1'b1;
        s_axis_data  = 17'd99;
        s_axis_last  = 1'b1;
        m_axis_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_axis_valid), 32'd0);
        chk("rst_m_data",  32'(m_axis_data),  32'd0);
        chk("rst_m_count", 32'(m_axis_count), 32'd0);
        chk("rst_m_ovf",   32'(m_axis_ovf),   32'd0);
        chk("rst_s_ready", 32'(s_axis_ready), 32'd1);
        rst = 1'b0;
        idle();
        chk("post_rst_no_result", 32'(m_axis_valid), 32'd0);

        // Three-beat packet, result one cycle after the last beat.
        drive(17'd10, 1'b0);
        drive(17'd20, 1'b0);
        chk("p1_not_early", 32'(m_axis_valid), 32'd0);
        drive(17'd30, 1'b1);
        result("p1", 32'd60, 32'd3, 1'b0);
        idle();
        chk("p1_valid_clear", 32'(m_axis_valid), 32'd0);

        // Single beat with a stalled consumer; held stable, input blocked.
        m_axis_ready = 1'b0;
        drive(17'd7, 1'b1);
        result("p2", 32'd7, 32'd1, 1'b0);
        chk("p2_s_ready_low", 32'(s_axis_ready), 32'd0);
        drive(17'd55, 1'b1);
        result("p2_hold1", 32'd7, 32'd1, 1'b0);
        idle();
        result("p2_hold2", 32'd7, 32'd1, 1'b0);
        chk("p2_s_ready_still_low", 32'(s_axis_ready), 32'd0);
        m_axis_ready = 1'b1;
        #1;
        chk("p2_s_ready_comb", 32'(s_axis_ready), 32'd1);
        @(negedge clk);
        chk("p2_taken", 32'(m_axis_valid), 32'd0);

        // Back-to-back packets, no bubble on the output.
        drive(17'd1, 1'b0);
        drive(17'd2, 1'b1);
        result("p3a", 32'd3, 32'd2, 1'b0);
        drive(17'd3, 1'b1);
        result("p3b", 32'd3, 32'd1, 1'b0);
        idle();
        chk("p3_valid_clear", 32'(m_axis_valid), 32'd0);

        // Sum saturation: 9 x 0x1FFFF = 0x11FFF7 > 0xFFFFF.
        for (int i = 0; i < 9; i++) drive(17'h1FFFF, (i == 8));
        result("sat", 32'hFFFFF, 32'd9, 1'b1);
        drive(17'd5, 1'b1);
        result("sat_next", 32'd5, 32'd1, 1'b0);
        idle();

        // Count saturation at 15 with 17 beats.
        for (int i = 0; i < 17; i++) drive(17'd1, (i == 16));
        result("cnt_sat", 32'd17, 32'd15, 1'b1);
        idle();

        // Idle inputs with valid low do nothing.
        s_axis_data = 17'd123;
        s_axis_last = 1'b1;
        @(negedge clk);
        chk("no_valid_no_effect", 32'(m_axis_valid), 32'd0);

        // Reset mid-packet discards the partial sum.
        drive(17'd4, 1'b0);
        drive(17'd4, 1'b0);
        s_axis_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_no_result", 32'(m_axis_valid), 32'd0);
        drive(17'd9, 1'b1);
        result("after_rst", 32'd9, 32'd1, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_packet_accum.md
DSP_PACKET_ACCUM -- requirements
Module: dsp_packet_accum

Interface
REQ-001 Parameter DATA_WIDTH, default 33, SHALL set the input sample width (2*16+1, the width of the multiply-add stage output).
REQ-002 Parameter ACC_WIDTH, default 48, SHALL set the accumulator and result width; ACC_WIDTH >= DATA_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the beat-counter width.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_axis_valid  in  1  input beat valid.
REQ-007 s_axis_data  in  DATA_WIDTH  unsigned product sample.
REQ-008 s_axis_last  in  1  final beat of the packet.
REQ-009 s_axis_ready  out  1  block accepts a beat this cycle.
REQ-010 m_axis_valid  out  1  packet result valid.
REQ-011 m_axis_data  out  ACC_WIDTH  packet sum.
REQ-012 m_axis_count  out  CNT_WIDTH  beats in the packet.
REQ-013 m_axis_ovf  out  1  sum or count saturated in this packet.
REQ-014 m_axis_last  out  1  tied to m_axis_valid; each result is a one-beat packet.
REQ-015 m_axis_ready  in  1  downstream accepts the result.

Function
REQ-016 Input transfer SHALL occur when s_axis_valid && s_axis_ready; output transfer SHALL occur when m_axis_valid && m_axis_ready.
REQ-017 s_axis_ready SHALL equal !m_axis_valid || m_axis_ready, combinationally.
REQ-018 Accumulator FSM SHALL have two states: IDLE (no beats of the current packet held) and ACC (one or more beats held).
REQ-019 IDLE, non-last transfer: acc <= data, cnt <= 1, ovf <= 0; go to ACC.
REQ-020 ACC, non-last transfer: acc <= acc + data, cnt <= cnt + 1, both saturating; stay in ACC.
REQ-021 Last transfer in either state: load the output register with the final sum, count and ovf (including this beat), set m_axis_valid, clear acc/cnt/ovf, and go to IDLE.
REQ-022 Latency: m_axis_valid SHALL rise on the cycle after the last beat transfers; one result per packet.
REQ-023 A single-beat packet (last on first beat) SHALL yield sum = data, count = 1.
REQ-024 Sum saturation: if the unsigned sum exceeds 2^ACC_WIDTH-1, acc SHALL hold all-ones and ovf SHALL set, sticky until the packet ends.
REQ-025 Count saturation: cnt SHALL hold at 2^CNT_WIDTH-1 and set ovf.
REQ-026 Output register SHALL hold data, count and ovf stable while m_axis_valid && !m_axis_ready.
REQ-027 On an output transfer with no new last beat, m_axis_valid SHALL clear the next cycle.
REQ-028 An output transfer and a new last beat in the same cycle SHALL reload the register with m_axis_valid staying 1, with no bubble.
REQ-029 Non-last beats of the next packet SHALL accumulate only while s_axis_ready is 1; no beat is dropped or duplicated.
REQ-030 Values on s_axis_data/last without valid SHALL have no effect.

Reset
REQ-031 While rst=1: FSM = IDLE; acc, cnt, ovf = 0; m_axis_valid = 0; m_axis_data = 0; m_axis_count = 0; m_axis_ovf = 0.
REQ-032 While rst=1, s_axis_ready SHALL read 1 (follows REQ-017); beats presented during reset SHALL be discarded.
REQ-033 Reset mid-packet SHALL discard the partial sum; the first beat after reset starts a new packet.

Structure
REQ-034 Package dsp_pkg SHALL hold the default widths, the FSM state enum (IDLE, ACC) and a saturating-add function.
REQ-035 A single sub-module, axis_out_reg (one-entry output slice holding data/count/ovf with valid/ready), is natural; the accumulator and FSM stay in the top.

Verification (DATA_WIDTH=17, ACC_WIDTH=20, CNT_WIDTH=4 where noted)
REQ-036 Beats 10, 20, 30(last) with m_axis_ready=1 -> one result: data=60, count=3, ovf=0, valid one cycle after the last beat.
REQ-037 Single beat 7 with last, m_axis_ready=0 for 3 cycles -> data=7, count=1 held stable; s_axis_ready=0 until the output is taken.
REQ-038 Back-to-back packets {1,2(last)}, {3(last)} with ready=1 -> results 3 then 3, m_axis_valid high on consecutive cycles.
REQ-039 Saturation: ACC_WIDTH=20, beats 0x1FFFF x 9 (last on 9th) -> data=0xFFFFF, ovf=1; the next packet {5(last)} -> data=5, ovf=0.
REQ-040 Count overflow: CNT_WIDTH=4, 17 beats of 1 -> count=15, ovf=1, data=17.
REQ-041 rst pulse after beats 4, 4 (no last), then 9(last) -> result data=9, count=1.
